// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared definitions for the stopwatch control and counter
//                stages: FSM state encodings, default timing constants,
//                pushbutton index assignments and a width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Default timing configuration
    localparam int unsigned CLK_HZ_DEF      = 50_000_000;
    localparam int unsigned TICK_HZ_DEF     = 100;
    localparam int unsigned DEBOUNCE_MS_DEF = 10;

    // Pushbutton indices into KEY[2:0]
    localparam int unsigned KEY_CLEAR = 0;
    localparam int unsigned KEY_START = 1;
    localparam int unsigned KEY_LAP   = 2;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One pushbutton front end: 2-flop synchroniser on the
//                inverted (active-low) key, debounce counter with a DB-cycle
//                stability window, and a one-cycle press pulse on each
//                debounced press. Releases produce no pulse.
//  Ports       : CLOCK_50  in  system clock
//                reset     in  synchronous active-high reset
//                key_n_i   in  raw active-low key
//                press_o   out one-cycle pulse per debounced press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned   CW       = cnt_width(DB);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

    logic          sync1_q;
    logic          s_q;
    logic          deb_q;
    logic          deb_dly_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= ~key_n_i;
            s_q       <= sync1_q;
            deb_dly_q <= deb_q;
            // Any return to agreement restarts the window, so bounces
            // shorter than DB cycles never reach the accept point.
            if (s_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_q <= s_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = deb_q & ~deb_dly_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Stopwatch front-end control. Debounces the three keys,
//                runs the IDLE/RUN/PAUSE FSM, generates the free-running
//                timebase tick and drives count enable / clear to the counter
//                stage. Lap logic is built only when STOPWATCH_LAP_EN is
//                defined; otherwise KEY[2] is ignored and lap_hold is 0.
//  Ports       : CLOCK_50  in  system clock
//                reset     in  synchronous active-high reset
//                KEY[2:0]  in  raw active-low keys (0 clear, 1 start, 2 lap)
//                tick      out one-cycle pulse every CLK_HZ/TICK_HZ cycles
//                count_en  out tick qualified by RUN
//                clear     out one-cycle counter clear pulse
//                running   out high in RUN
//                lap_hold  out display freeze request
//                state[1:0]out FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ     = TICK_HZ_DEF,
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] KEY,
    output logic       tick,
    output logic       count_en,
    output logic       clear,
    output logic       running,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int unsigned   DIV      = CLK_HZ / TICK_HZ;
    localparam int unsigned   DB       = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned   DW       = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          w_press_clr;
    logic          w_press_start;
    logic          w_press_lap;
    logic          w_lap_hold;
    logic [DW-1:0] div_q, div_d;
    state_t        state_q, state_d;
    logic          clear_q, clear_d;

    // ---------------------------------------------------------------- keys
    key_debounce #(.DB(DB)) u_db_clear (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n_i  (KEY[KEY_CLEAR]),
        .press_o  (w_press_clr)
    );

    key_debounce #(.DB(DB)) u_db_start (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n_i  (KEY[KEY_START]),
        .press_o  (w_press_start)
    );

`ifdef STOPWATCH_LAP_EN
    logic lap_q, lap_d;

    key_debounce #(.DB(DB)) u_db_lap (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n_i  (KEY[KEY_LAP]),
        .press_o  (w_press_lap)
    );

    // Lap only reacts when neither clear nor start/stop is pressed.
    always_comb begin
        lap_d = lap_q;
        if (w_press_clr) begin
            lap_d = 1'b0;
        end else if (!w_press_start && w_press_lap) begin
            if (state_q == ST_RUN) begin
                lap_d = ~lap_q;
            end else if (state_q == ST_PAUSE) begin
                lap_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign w_lap_hold = lap_q;
`else
    logic w_key_lap_unused;

    assign w_key_lap_unused = KEY[KEY_LAP];
    assign w_press_lap      = 1'b0;
    assign w_lap_hold       = 1'b0;
`endif

    // ------------------------------------------------------------ timebase
    // Restart on the registered clear so the first tick after a clear is a
    // full DIV cycles after the clear pulse.
    always_comb begin
        div_d = div_q + 1'b1;
        if (clear_q || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (w_press_clr) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else if (w_press_start) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running  = (state_q == ST_RUN);
        count_en = tick & (state_q == ST_RUN);
        clear    = clear_q;
        lap_hold = w_lap_hold;
        state    = state_q;
    end

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed testbench for stopwatch_ctrl with CLK_HZ=1000,
//                TICK_HZ=100 (DIV=10), DEBOUNCE_MS=4 (DB=4). Inputs change
//                and outputs are sampled 1 time unit after each rising edge.
//                Comments track the cycle index j (window after edge j) and
//                the expected divider phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_ON = 1'b1;
`else
    localparam logic LAP_ON = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [2:0] KEY;
    logic       tick;
    logic       count_en;
    logic       clear;
    logic       running;
    logic       lap_hold;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    stopwatch_ctrl #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .DEBOUNCE_MS (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .tick     (tick),
        .count_en (count_en),
        .clear    (clear),
        .running  (running),
        .lap_hold (lap_hold),
        .state    (state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a key low 20 cycles, release, settle 10: 30 cycles total, so the
    // divider phase is preserved. The effect lands 7 cycles after the fall.
    task automatic press(input int idx);
        KEY[idx] = 1'b0;
        step(20);
        KEY[idx] = 1'b1;
        step(10);
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 3'b111;

        // 1. Reset
        step(1);
        chk("rst1_state", state, 0);
        chk("rst1_tick", tick, 0);
        chk("rst1_clear", clear, 0);
        step(2);
        chk("rst3_state", state, 0);
        chk("rst3_running", running, 0);
        chk("rst3_lap", lap_hold, 0);
        chk("rst3_clear", clear, 0);
        chk("rst3_tick", tick, 0);
        chk("rst3_cen", count_en, 0);
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin      // j=0: divider 0
            chk("idle_tick", tick, ((j % 10) == 9) ? 1 : 0);
            chk("idle_cen", count_en, 0);
            step(1);
        end

        // 2. Start/stop, fall at j=20
        KEY[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("start_lat", state, (k == 7) ? 1 : 0);
        end
        step(2);                                 // j=29, divider 9
        chk("run_tick", tick, 1);
        chk("run_cen", count_en, 1);
        step(10);                                // j=39
        chk("run_cen2", count_en, 1);
        chk("held_once", state, 1);
        step(1);                                 // j=40
        KEY[1] = 1'b1;
        step(10);                                // j=50
        chk("held_after", state, 1);
        press(1);                                // j=80
        chk("pause_state", state, 2);
        chk("pause_running", running, 0);
        step(9);                                 // j=89
        chk("pause_tick", tick, 1);
        chk("pause_cen", count_en, 0);
        step(1);
        press(1);                                // j=120
        chk("resume_state", state, 1);
        chk("resume_running", running, 1);
        step(9);
        chk("resume_cen", count_en, 1);
        step(1);                                 // j=130

        // 3. Bounce: 2-cycle low/high segments
        repeat (3) begin
            KEY[1] = 1'b0;
            step(2);
            KEY[1] = 1'b1;
            step(2);
        end
        step(8);                                 // j=150
        chk("bounce_state", state, 1);

        // 4. Clear and start together
        KEY = 3'b100;
        step(6);                                 // j=156
        chk("clr_pre", clear, 0);
        chk("clr_pre_state", state, 1);
        step(1);                                 // j=157
        chk("clr_pulse", clear, 1);
        chk("clr_state", state, 0);
        chk("clr_running", running, 0);
        step(1);                                 // j=158, divider restarted
        chk("clr_one_cycle", clear, 0);
        step(8);                                 // j=166
        chk("clr_tick_early", tick, 0);
        step(1);                                 // j=167
        chk("clr_tick10", tick, 1);
        chk("clr_cen", count_en, 0);
        step(3);                                 // j=170
        KEY = 3'b111;
        step(8);                                 // j=178, divider 0

        // 5. Lap
        press(1);                                // j=208
        chk("lap_run", state, 1);
        press(2);                                // j=238
        chk("lap_set", lap_hold, LAP_ON);
        chk("lap_state", state, 1);
        step(9);
        chk("lap_cen", count_en, 1);
        step(1);
        press(2);                                // j=278
        chk("lap_toggle", lap_hold, 0);
        press(2);                                // j=308
        chk("lap_set2", lap_hold, LAP_ON);
        press(1);                                // j=338
        chk("lap_pause", state, 2);
        chk("lap_kept", lap_hold, LAP_ON);
        press(2);                                // j=368
        chk("lap_pause_clr", lap_hold, 0);
        chk("lap_pause_state", state, 2);

        // 6. Reset mid-debounce: s high at j=370, cnt=3 at j=373
        KEY[1] = 1'b0;
        step(5);                                 // j=373
        reset = 1'b1;
        step(1);                                 // j=374
        reset = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_clear", clear, 0);
        chk("mid_rst_tick", tick, 0);
        step(6);                                 // j=380
        chk("mid_rst_early", state, 0);
        step(1);                                 // j=381
        chk("mid_rst_press", state, 1);
        step(2);                                 // j=383, divider 9
        chk("mid_rst_tick9", tick, 1);
        chk("mid_rst_cen", count_en, 1);
        KEY = 3'b111;
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
